// File: rtl/mem_ctrl_if.sv
// rtl/mem_ctrl_if.sv - fetch port, data port and memory-side bus of mem_ctrl
interface mem_ctrl_if;
    logic        f_req;
    logic [15:0] f_addr;
    logic        f_ack;
    logic        f_rvalid;

    logic        d_req;
    logic        d_we;
    logic [15:0] d_addr;
    logic [15:0] d_wdata;
    logic        d_ack;
    logic        d_rvalid;
    logic        d_done;

    logic [15:0] rdata;

    logic [1:0]  mem_mode;
    logic [15:0] mem_addr;
    logic [15:0] mem_din;
    logic [15:0] mem_dout;

    modport slave (
        input  f_req, f_addr, d_req, d_we, d_addr, d_wdata, mem_dout,
        output f_ack, f_rvalid, d_ack, d_rvalid, d_done, rdata,
               mem_mode, mem_addr, mem_din
    );

    modport master (
        output f_req, f_addr, d_req, d_we, d_addr, d_wdata, mem_dout,
        input  f_ack, f_rvalid, d_ack, d_rvalid, d_done, rdata,
               mem_mode, mem_addr, mem_din
    );
endinterface

// File: rtl/mem_ctrl.sv
// rtl/mem_ctrl.sv - fetch/data arbiter and sequencer for a synchronous 16-bit word memory
module mem_ctrl #(
    parameter int FETCH_MAX = 4
) (
    input  logic       clk,
    input  logic       rstn,
    mem_ctrl_if.slave  bus
);

    localparam logic [1:0] MODE_NONE  = 2'b00;
    localparam logic [1:0] MODE_IN    = 2'b01;
    localparam logic [1:0] MODE_OUT   = 2'b10;
    localparam logic [2:0] STARVE_MAX = 3'(FETCH_MAX);

    typedef enum logic [1:0] {IDLE, RD, RCAP, WR} state_t;

    state_t      state;
    state_t      next_state;
    logic [2:0]  starve_cnt;
    logic        txn_fetch;
    logic        fetch_win;
    logic        data_win;
    logic        f_ack;
    logic        d_ack;
    logic [1:0]  mode_next;
    logic [1:0]  mem_mode;
    logic [15:0] mem_addr;
    logic [15:0] mem_din;
    logic [15:0] rdata;
    logic        f_rvalid;
    logic        d_rvalid;
    logic        d_done;

    // Data has priority unless fetch has been passed over FETCH_MAX times in a row.
    assign fetch_win = bus.f_req & (~bus.d_req | (starve_cnt == STARVE_MAX));
    assign data_win  = bus.d_req & ~fetch_win;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (fetch_win) begin
                    next_state = RD;
                end else if (data_win) begin
                    next_state = bus.d_we ? WR : RD;
                end
            end
            RD:      next_state = RCAP;
            RCAP:    next_state = IDLE;
            WR:      next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Acks are masked by rstn so nothing is accepted while reset is held.
    always_comb begin
        f_ack     = 1'b0;
        d_ack     = 1'b0;
        mode_next = MODE_NONE;
        if (rstn && state == IDLE) begin
            f_ack = fetch_win;
            d_ack = data_win;
        end
        case (next_state)
            RD:      mode_next = MODE_OUT;
            WR:      mode_next = MODE_IN;
            default: mode_next = MODE_NONE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            mem_mode   <= MODE_NONE;
            mem_addr   <= '0;
            mem_din    <= '0;
            rdata      <= '0;
            f_rvalid   <= 1'b0;
            d_rvalid   <= 1'b0;
            d_done     <= 1'b0;
            txn_fetch  <= 1'b0;
            starve_cnt <= '0;
        end else begin
            mem_mode <= mode_next;
            f_rvalid <= (state == RCAP) &  txn_fetch;
            d_rvalid <= (state == RCAP) & ~txn_fetch;
            d_done   <= (state == WR);

            if (state == RCAP) begin
                rdata <= bus.mem_dout;
            end

            if (f_ack) begin
                mem_addr  <= bus.f_addr;
                txn_fetch <= 1'b1;
            end else if (d_ack) begin
                mem_addr  <= bus.d_addr;
                mem_din   <= bus.d_wdata;
                txn_fetch <= 1'b0;
            end

            if (state == IDLE) begin
                if (f_ack || !bus.f_req) begin
                    starve_cnt <= '0;
                end else if (d_ack && starve_cnt != STARVE_MAX) begin
                    starve_cnt <= starve_cnt + 3'd1;
                end
            end
        end
    end

    assign bus.f_ack    = f_ack;
    assign bus.d_ack    = d_ack;
    assign bus.f_rvalid = f_rvalid;
    assign bus.d_rvalid = d_rvalid;
    assign bus.d_done   = d_done;
    assign bus.rdata    = rdata;
    assign bus.mem_mode = mem_mode;
    assign bus.mem_addr = mem_addr;
    assign bus.mem_din  = mem_din;

endmodule

// File: tb/tb_mem_ctrl.sv
// tb/tb_mem_ctrl.sv - scoreboard bench for mem_ctrl with a synchronous word-memory model
module tb_mem_ctrl;
    logic clk  = 1'b0;
    logic rstn = 1'b0;

    mem_ctrl_if bus();

    mem_ctrl #(.FETCH_MAX(4)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    // kind: 0 fetch read, 1 data load, 2 store done, 3 overlapping pulses
    typedef struct {
        int          kind;
        logic [15:0] data;
    } ev_t;

    ev_t         exp_q[$];
    int          n_cmp   = 0;
    int          n_bad   = 0;
    int          obs_kind [0:1023];
    logic [15:0] obs_data [0:1023];
    int          obs_cnt = 0;
    int          rd_ptr  = 0;

    logic [15:0] mem [0:65535];
    logic        mem_ready = 1'b0;
    logic [15:0] shadow [logic [15:0]];

    function automatic logic [15:0] pattern(input logic [15:0] a);
        return (a == 16'h0010) ? 16'hBEEF : (a ^ 16'hA5C3);
    endfunction

    function automatic logic [15:0] expect_word(input logic [15:0] a);
        return shadow.exists(a) ? shadow[a] : pattern(a);
    endfunction

    always @(posedge clk) begin
        if (!mem_ready) begin
            for (int i = 0; i < 65536; i++) mem[i] <= pattern(16'(i));
            mem_ready <= 1'b1;
        end else if (bus.mem_mode == 2'b01) begin
            mem[bus.mem_addr] <= bus.mem_din;
        end else if (bus.mem_mode == 2'b10) begin
            bus.mem_dout <= mem[bus.mem_addr];
        end
    end

    always @(negedge clk) begin
        if (bus.f_rvalid || bus.d_rvalid || bus.d_done) begin
            if (obs_cnt < 1024) begin
                obs_kind[obs_cnt] <= (int'(bus.f_rvalid) + int'(bus.d_rvalid) + int'(bus.d_done) > 1) ? 3 :
                                     bus.f_rvalid ? 0 : (bus.d_rvalid ? 1 : 2);
                obs_data[obs_cnt] <= bus.rdata;
            end
            obs_cnt <= obs_cnt + 1;
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic drain();
        for (int i = 0; i < 60 && (obs_cnt - rd_ptr) < exp_q.size(); i++) step();
        step();
    endtask

    task automatic test_reset();
        ev_t e;
        rstn = 1'b0;
        bus.f_req = 1'b1; bus.f_addr = 16'h0010;
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 16'h0000; bus.d_wdata = 16'h0000;
        step(); step(); #1;
        n_cmp++; if ({bus.f_ack, bus.d_ack} !== 2'b00) begin n_bad++; $display("FAIL reset_ack: got %b want 00", {bus.f_ack, bus.d_ack}); end
        n_cmp++; if (bus.mem_mode !== 2'b00) begin n_bad++; $display("FAIL reset_mode: got %b want 00", bus.mem_mode); end
        n_cmp++; if ({bus.f_rvalid, bus.d_rvalid, bus.d_done} !== 3'b000) begin n_bad++; $display("FAIL reset_pulses: got %b want 000", {bus.f_rvalid, bus.d_rvalid, bus.d_done}); end
        n_cmp++; if ({bus.rdata, bus.mem_addr, bus.mem_din} !== 48'h0) begin n_bad++; $display("FAIL reset_regs: got %h want 0", {bus.rdata, bus.mem_addr, bus.mem_din}); end
        step();
        rstn = 1'b1;
        #1;
        n_cmp++; if ({bus.f_ack, bus.d_ack} !== 2'b01) begin n_bad++; $display("FAIL reset_release_ack: got %b want 01", {bus.f_ack, bus.d_ack}); end
        exp_q.push_back(ev_t'{kind: 1, data: expect_word(16'h0000)});
        step();
        bus.f_req = 1'b0; bus.d_req = 1'b0;
        drain();
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); n_cmp++;
            if (rd_ptr >= obs_cnt) begin n_bad++; $display("FAIL reset_sb: got no pulse want kind %0d data %h", e.kind, e.data); end
            else begin
                if (obs_kind[rd_ptr] !== e.kind || (e.kind != 2 && obs_data[rd_ptr] !== e.data)) begin
                    n_bad++; $display("FAIL reset_sb: got kind %0d data %h want kind %0d data %h", obs_kind[rd_ptr], obs_data[rd_ptr], e.kind, e.data);
                end
                rd_ptr++;
            end
        end
    endtask

    task automatic test_fetch_read();
        ev_t e;
        bus.f_req = 1'b1; bus.f_addr = 16'h0010;
        #1;
        n_cmp++; if (bus.f_ack !== 1'b1) begin n_bad++; $display("FAIL fetch_ack: got %b want 1", bus.f_ack); end
        exp_q.push_back(ev_t'{kind: 0, data: expect_word(16'h0010)});
        step();
        bus.f_req = 1'b0;
        #1;
        n_cmp++; if (bus.mem_mode !== 2'b10 || bus.mem_addr !== 16'h0010) begin n_bad++; $display("FAIL fetch_rd_cycle: got mode %b addr %h want 10 0010", bus.mem_mode, bus.mem_addr); end
        step();
        n_cmp++; if (bus.mem_mode !== 2'b00) begin n_bad++; $display("FAIL fetch_rcap_mode: got %b want 00", bus.mem_mode); end
        step();
        n_cmp++; if (bus.f_rvalid !== 1'b1 || bus.rdata !== 16'hBEEF) begin n_bad++; $display("FAIL fetch_rvalid: got %b %h want 1 beef", bus.f_rvalid, bus.rdata); end
        drain();
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); n_cmp++;
            if (rd_ptr >= obs_cnt) begin n_bad++; $display("FAIL fetch_sb: got no pulse want kind %0d data %h", e.kind, e.data); end
            else begin
                if (obs_kind[rd_ptr] !== e.kind || (e.kind != 2 && obs_data[rd_ptr] !== e.data)) begin
                    n_bad++; $display("FAIL fetch_sb: got kind %0d data %h want kind %0d data %h", obs_kind[rd_ptr], obs_data[rd_ptr], e.kind, e.data);
                end
                rd_ptr++;
            end
        end
    endtask

    task automatic test_store_load();
        ev_t e;
        bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 16'hFFFF; bus.d_wdata = 16'h1234;
        #1;
        n_cmp++; if (bus.d_ack !== 1'b1) begin n_bad++; $display("FAIL store_ack: got %b want 1", bus.d_ack); end
        exp_q.push_back(ev_t'{kind: 2, data: 16'h0000});
        shadow[16'hFFFF] = 16'h1234;
        step();
        bus.d_req = 1'b0;
        #1;
        n_cmp++; if (bus.mem_mode !== 2'b01 || bus.mem_addr !== 16'hFFFF || bus.mem_din !== 16'h1234) begin
            n_bad++; $display("FAIL store_wr_cycle: got %b %h %h want 01 ffff 1234", bus.mem_mode, bus.mem_addr, bus.mem_din);
        end
        step();
        n_cmp++; if (bus.d_done !== 1'b1 || bus.mem_mode !== 2'b00) begin n_bad++; $display("FAIL store_done: got done %b mode %b want 1 00", bus.d_done, bus.mem_mode); end
        bus.d_req = 1'b1; bus.d_we = 1'b0;
        #1;
        n_cmp++; if (bus.d_ack !== 1'b1) begin n_bad++; $display("FAIL load_ack_on_done: got %b want 1", bus.d_ack); end
        exp_q.push_back(ev_t'{kind: 1, data: expect_word(16'hFFFF)});
        step();
        bus.d_req = 1'b0;
        drain();
        n_cmp++; if (mem[16'hFFFF] !== 16'h1234) begin n_bad++; $display("FAIL store_mem_word: got %h want 1234", mem[16'hFFFF]); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); n_cmp++;
            if (rd_ptr >= obs_cnt) begin n_bad++; $display("FAIL store_load_sb: got no pulse want kind %0d data %h", e.kind, e.data); end
            else begin
                if (obs_kind[rd_ptr] !== e.kind || (e.kind != 2 && obs_data[rd_ptr] !== e.data)) begin
                    n_bad++; $display("FAIL store_load_sb: got kind %0d data %h want kind %0d data %h", obs_kind[rd_ptr], obs_data[rd_ptr], e.kind, e.data);
                end
                rd_ptr++;
            end
        end
    endtask

    task automatic test_priority();
        ev_t e;
        int  got;
        bus.f_req = 1'b1; bus.f_addr = 16'h0020;
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 16'h0030;
        #1;
        n_cmp++; if ({bus.f_ack, bus.d_ack} !== 2'b01) begin n_bad++; $display("FAIL prio_first: got %b want 01", {bus.f_ack, bus.d_ack}); end
        exp_q.push_back(ev_t'{kind: 1, data: expect_word(16'h0030)});
        step();
        bus.d_req = 1'b0;
        got = -1;
        for (int i = 1; i <= 10; i++) begin
            #1;
            if (bus.f_ack === 1'b1) begin got = i; break; end
            step();
        end
        n_cmp++; if (got != 3) begin n_bad++; $display("FAIL prio_fetch_cycle: got %0d want 3", got); end
        if (got > 0) exp_q.push_back(ev_t'{kind: 0, data: expect_word(16'h0020)});
        step();
        bus.f_req = 1'b0;
        drain();
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); n_cmp++;
            if (rd_ptr >= obs_cnt) begin n_bad++; $display("FAIL prio_sb: got no pulse want kind %0d data %h", e.kind, e.data); end
            else begin
                if (obs_kind[rd_ptr] !== e.kind || (e.kind != 2 && obs_data[rd_ptr] !== e.data)) begin
                    n_bad++; $display("FAIL prio_sb: got kind %0d data %h want kind %0d data %h", obs_kind[rd_ptr], obs_data[rd_ptr], e.kind, e.data);
                end
                rd_ptr++;
            end
        end
    endtask

    task automatic test_starvation();
        ev_t  e;
        logic seq [6];
        logic exp_seq [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        logic gf, gd;
        int   n = 0;
        bus.f_req = 1'b1; bus.f_addr = 16'h0040;
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 16'h0100;
        for (int c = 0; c < 60 && n < 6; c++) begin
            #1;
            gf = bus.f_ack; gd = bus.d_ack;
            if (gd === 1'b1) exp_q.push_back(ev_t'{kind: 1, data: expect_word(bus.d_addr)});
            if (gf === 1'b1) exp_q.push_back(ev_t'{kind: 0, data: expect_word(bus.f_addr)});
            if (gf === 1'b1 || gd === 1'b1) begin seq[n] = gf; n++; end
            step();
            if (gd === 1'b1) bus.d_addr = bus.d_addr + 16'd1;
        end
        bus.f_req = 1'b0; bus.d_req = 1'b0;
        n_cmp++; if (n != 6) begin n_bad++; $display("FAIL starve_grants: got %0d want 6", n); end
        for (int i = 0; i < n; i++) begin
            n_cmp++;
            if (seq[i] !== exp_seq[i]) begin n_bad++; $display("FAIL starve_seq[%0d]: got fetch=%b want fetch=%b", i, seq[i], exp_seq[i]); end
        end
        drain();
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); n_cmp++;
            if (rd_ptr >= obs_cnt) begin n_bad++; $display("FAIL starve_sb: got no pulse want kind %0d data %h", e.kind, e.data); end
            else begin
                if (obs_kind[rd_ptr] !== e.kind || (e.kind != 2 && obs_data[rd_ptr] !== e.data)) begin
                    n_bad++; $display("FAIL starve_sb: got kind %0d data %h want kind %0d data %h", obs_kind[rd_ptr], obs_data[rd_ptr], e.kind, e.data);
                end
                rd_ptr++;
            end
        end
    endtask

    task automatic test_back_to_back();
        ev_t  e;
        int   ack_cyc [3];
        int   n;
        logic got;
        for (int pass = 0; pass < 2; pass++) begin
            n = 0;
            bus.d_we = (pass == 0); bus.d_addr = 16'h0200; bus.d_wdata = 16'h1007; bus.d_req = 1'b1;
            for (int c = 0; c < 30 && n < 3; c++) begin
                #1;
                got = bus.d_ack;
                if (got === 1'b1) begin
                    if (pass == 0) begin
                        exp_q.push_back(ev_t'{kind: 2, data: 16'h0000});
                        shadow[bus.d_addr] = bus.d_wdata;
                    end else begin
                        exp_q.push_back(ev_t'{kind: 1, data: expect_word(bus.d_addr)});
                    end
                    ack_cyc[n] = c; n++;
                end
                step();
                if (got === 1'b1) begin bus.d_addr = bus.d_addr + 16'd1; bus.d_wdata = bus.d_wdata + 16'h0111; end
            end
            bus.d_req = 1'b0;
            n_cmp++;
            if (n != 3 || ack_cyc[1] - ack_cyc[0] != 2 + pass || ack_cyc[2] - ack_cyc[1] != 2 + pass) begin
                n_bad++; $display("FAIL b2b_gap_pass%0d: got n=%0d gaps %0d %0d want %0d", pass, n, ack_cyc[1] - ack_cyc[0], ack_cyc[2] - ack_cyc[1], 2 + pass);
            end
            drain();
            while (exp_q.size() > 0) begin
                e = exp_q.pop_front(); n_cmp++;
                if (rd_ptr >= obs_cnt) begin n_bad++; $display("FAIL b2b_sb: got no pulse want kind %0d data %h", e.kind, e.data); end
                else begin
                    if (obs_kind[rd_ptr] !== e.kind || (e.kind != 2 && obs_data[rd_ptr] !== e.data)) begin
                        n_bad++; $display("FAIL b2b_sb: got kind %0d data %h want kind %0d data %h", obs_kind[rd_ptr], obs_data[rd_ptr], e.kind, e.data);
                    end
                    rd_ptr++;
                end
            end
        end
    endtask

    task automatic test_reset_mid_store();
        ev_t e;
        bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 16'h0050; bus.d_wdata = 16'hDEAD;
        #1;
        n_cmp++; if (bus.d_ack !== 1'b1) begin n_bad++; $display("FAIL rst_wr_ack: got %b want 1", bus.d_ack); end
        step();
        bus.d_req = 1'b0;
        #1;
        n_cmp++; if (bus.mem_mode !== 2'b01) begin n_bad++; $display("FAIL rst_wr_mode_before: got %b want 01", bus.mem_mode); end
        rstn = 1'b0;
        #1;
        n_cmp++; if (bus.mem_mode !== 2'b00) begin n_bad++; $display("FAIL rst_wr_mode_drop: got %b want 00", bus.mem_mode); end
        step();
        rstn = 1'b1;
        step(); step();
        n_cmp++; if (mem[16'h0050] !== expect_word(16'h0050)) begin n_bad++; $display("FAIL rst_wr_mem_word: got %h want %h", mem[16'h0050], expect_word(16'h0050)); end
        n_cmp++; if (obs_cnt != rd_ptr) begin n_bad++; $display("FAIL rst_wr_no_done: got %0d pulses want 0", obs_cnt - rd_ptr); end
        bus.f_req = 1'b1; bus.f_addr = 16'h0010;
        #1;
        n_cmp++; if (bus.f_ack !== 1'b1) begin n_bad++; $display("FAIL rst_wr_reissue_ack: got %b want 1", bus.f_ack); end
        exp_q.push_back(ev_t'{kind: 0, data: expect_word(16'h0010)});
        step();
        bus.f_req = 1'b0;
        drain();
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); n_cmp++;
            if (rd_ptr >= obs_cnt) begin n_bad++; $display("FAIL rst_wr_sb: got no pulse want kind %0d data %h", e.kind, e.data); end
            else begin
                if (obs_kind[rd_ptr] !== e.kind || (e.kind != 2 && obs_data[rd_ptr] !== e.data)) begin
                    n_bad++; $display("FAIL rst_wr_sb: got kind %0d data %h want kind %0d data %h", obs_kind[rd_ptr], obs_data[rd_ptr], e.kind, e.data);
                end
                rd_ptr++;
            end
        end
    endtask

    initial begin
        bus.f_req = 1'b0; bus.f_addr = '0;
        bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_addr = '0; bus.d_wdata = '0;
        test_reset();
        test_fetch_read();
        test_store_load();
        test_priority();
        test_starvation();
        test_back_to_back();
        test_reset_mid_store();
        n_cmp++;
        if (exp_q.size() != 0 || obs_cnt != rd_ptr) begin
            n_bad++; $display("FAIL final_drain: got %0d pending %0d stray want 0 0", exp_q.size(), obs_cnt - rd_ptr);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/mem_ctrl.md
# mem_ctrl

Memory access controller sitting directly upstream of the 16-bit word memory. Arbitrates between the instruction-fetch port (read-only) and the data port (load/store). Sequences each accepted request into the memory's synchronous mode/address/data protocol, and returns read data with a one-cycle valid pulse. One transaction is in flight at a time; a starvation counter bounds how long fetch can be locked out by data traffic.

## Interface
- FETCH_MAX, default 4: consecutive data grants while fetch waits before fetch is forced to win; legal range 1..7.
- clk  in  1  system clock; all state changes on posedge.
- rstn  in  1  asynchronous, active-low reset.
- f_req  in  1  fetch read request; held with f_addr until f_ack.
- f_addr  in  16  fetch word address.
- f_ack  out  1  fetch request accepted this cycle.
- f_rvalid  out  1  one-cycle pulse: rdata holds fetch result.
- d_req  in  1  data request; held with d_we/d_addr/d_wdata until d_ack.
- d_we  in  1  1 = store, 0 = load.
- d_addr  in  16  data word address.
- d_wdata  in  16  store data.
- d_ack  out  1  data request accepted this cycle.
- d_rvalid  out  1  one-cycle pulse: rdata holds load result.
- d_done  out  1  one-cycle pulse: store committed to memory.
- rdata  out  16  shared read-return register.
- mem_mode  out  2  to memory: memModeNone = 2'b00, memModeIn (write) = 2'b01, memModeOut (read) = 2'b10.
- mem_addr  out  16  to memory address.
- mem_din  out  16  to memory data_in.
- mem_dout  in  16  from memory data_out.

## Operation
- FSM states: IDLE, RD, RCAP, WR.
- IDLE: grant is evaluated combinationally. If the winning request is a read, the edge moves to RD. If it is a store, the edge moves to WR. With no request, stay in IDLE.
- Acknowledges: f_ack/d_ack = (state==IDLE) & granted. Request fields are sampled at that edge into mem_addr/mem_din and the transaction type.
- RD: mem_mode = memModeOut. The next edge goes to RCAP.
- RCAP: mem_mode = memModeNone and mem_dout is valid. The edge loads rdata ← mem_dout, sets the matching rvalid for the following cycle, and returns to IDLE.
- WR: mem_mode = memModeIn. The memory writes at the next edge. That edge goes to IDLE with d_done = 1 for one cycle.
- rvalid/d_done pulses occur in the IDLE cycle that can also accept the next request.
- Arbitration:
  - Data wins by default.
  - Fetch wins when f_req & (starve_cnt == FETCH_MAX), or when d_req = 0.
  - starve_cnt (3 bits) increments on each data grant while f_req = 1, saturating at FETCH_MAX.
  - starve_cnt clears on a fetch grant or whenever f_req = 0 in IDLE.
- rdata holds its value until the next RCAP edge. mem_addr/mem_din hold their last values when idle.
- Full 16-bit address space is passed through unchanged, with no wrap or masking.
- Reset (rstn low, asynchronous):
  - state = IDLE, starve_cnt = 0, mem_mode = memModeNone.
  - mem_addr, mem_din, rdata = 0.
  - f_ack, d_ack, f_rvalid, d_rvalid, d_done = 0.
  - Reset during WR before the edge suppresses the write, because mode drops immediately.
  - Reset during RD/RCAP discards the read and produces no rvalid.
  - Requesters must re-issue after reset.

## Timing
- mem_mode, mem_addr, mem_din, rdata and the rvalid/d_done pulses are registered. Acks are combinational from state and requests.
- Read: accept in cycle 0 → RD in cycle 1 → RCAP in cycle 2 → rvalid + rdata in cycle 3. Back-to-back reads accepted every 3 cycles.
- Store: accept in cycle 0 → WR in cycle 1 → d_done in cycle 2. Back-to-back stores accepted every 2 cycles.
- Acks never assert outside IDLE. At most one ack per cycle.

## Test plan
- Reset: hold rstn = 0 with f_req = d_req = 1 → all outputs 0, mem_mode = 00, no ack. Release rstn → d_ack in the first IDLE cycle.
- Fetch read: memory preloaded with mem[0x0010] = 0xBEEF; f_req at cycle 0 with f_addr = 0x0010 → f_ack in cycle 0, mem_mode = 10 in cycle 1, f_rvalid = 1 and rdata = 0xBEEF in cycle 3.
- Store then load: d_we = 1, d_addr = 0xFFFF, d_wdata = 0x1234 → mem_mode = 01 for one cycle, d_done 2 cycles after ack. Then load 0xFFFF → d_rvalid with rdata = 0x1234.
- Priority: f_req and d_req both asserted in the same IDLE cycle with starve_cnt = 0 → d_ack first. Fetch is served once d_req drops.
- Starvation: f_req and d_req held continuously (loads) with FETCH_MAX = 4 → grant sequence D, D, D, D, F, D, …
- Reset mid-store: pull rstn low during WR, before the edge → mem_mode = 00 immediately, target memory word unchanged, no d_done.
